// File: rtl/rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_port_arbiter
// Purpose  : Shares one single-port game ROM/RAM between the HPS downloader,
//            video fetch and CPU; gates the game reset until download settles.
//            Optional download checksum: define ROM_ARBITER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rom_port_arbiter #(
  parameter int ADDR_W      = 14,
  parameter int ROM_SIZE    = 16384,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  output logic              dn_wait,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic [7:0]        cpu_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_q,
`ifdef ROM_ARBITER_CHECKSUM_EN
  output logic [7:0]        dn_sum,
  output logic              dn_sum_valid,
`endif
  output logic              game_reset_n
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]        state_q,    state_d;
  logic              buf_full_q, buf_full_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [7:0]        buf_data_q, buf_data_d;
  logic              rd_cpu_q,   rd_cpu_d;
  logic              pend_q,     pend_d;
  logic              vid_ack_q,  vid_ack_d;
  logic              cpu_ack_q,  cpu_ack_d;
  logic [7:0]        vid_data_q, vid_data_d;
  logic [7:0]        cpu_data_q, cpu_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q,  mem_din_d;
  logic              mem_we_q,   mem_we_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic w_in_range;
  logic w_accept;
  logic w_vid_busy;
  logic w_cpu_busy;

  assign w_in_range = (32'(dn_addr) < ROM_SIZE);
  assign w_accept   = dn_wr & w_in_range & ~buf_full_q;

  // A requester whose read is in flight or just acked still holds req high;
  // mask it so the same request is not granted twice.
  assign w_vid_busy = vid_ack_q | (pend_q & ~rd_cpu_q);
  assign w_cpu_busy = cpu_ack_q | (pend_q &  rd_cpu_q);

  always_comb begin
    state_d    = state_q;
    buf_full_d = buf_full_q;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    rd_cpu_d   = rd_cpu_q;
    pend_d     = (state_q == S_RD);
    vid_ack_d  = 1'b0;
    cpu_ack_d  = 1'b0;
    vid_data_d = vid_data_q;
    cpu_data_d = cpu_data_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;

    if (w_accept) begin
      buf_full_d = 1'b1;
      buf_addr_d = dn_addr;
      buf_data_d = dn_data;
    end

    if (pend_q) begin
      if (rd_cpu_q) begin
        cpu_data_d = mem_q;
        cpu_ack_d  = 1'b1;
      end else begin
        vid_data_d = mem_q;
        vid_ack_d  = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (buf_full_q) begin
          state_d    = S_WR;
          mem_addr_d = buf_addr_q;
          mem_din_d  = buf_data_q;
          mem_we_d   = 1'b1;
          buf_full_d = 1'b0;
        end else if (vid_req && !w_vid_busy && !dn_download) begin
          state_d    = S_RD;
          mem_addr_d = vid_addr;
          rd_cpu_d   = 1'b0;
        end else if (cpu_req && !w_cpu_busy && !dn_download) begin
          state_d    = S_RD;
          mem_addr_d = cpu_addr;
          rd_cpu_d   = 1'b1;
        end
      end
      S_RD:    state_d = S_IDLE;
      S_WR:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!reset_n || dn_download) begin
      cnt_d = CNT_INIT;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      buf_full_q <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
      rd_cpu_q   <= 1'b0;
      pend_q     <= 1'b0;
      vid_ack_q  <= 1'b0;
      cpu_ack_q  <= 1'b0;
      vid_data_q <= '0;
      cpu_data_q <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      cnt_q      <= CNT_INIT;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
      rd_cpu_q   <= rd_cpu_d;
      pend_q     <= pend_d;
      vid_ack_q  <= vid_ack_d;
      cpu_ack_q  <= cpu_ack_d;
      vid_data_q <= vid_data_d;
      cpu_data_q <= cpu_data_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      cnt_q      <= cnt_d;
    end
  end

  assign dn_wait      = buf_full_q;
  assign vid_ack      = vid_ack_q;
  assign cpu_ack      = cpu_ack_q;
  assign vid_data     = vid_data_q;
  assign cpu_data     = cpu_data_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign mem_we       = mem_we_q;
  assign game_reset_n = reset_n & ~dn_download & (cnt_q == '0);

`ifdef ROM_ARBITER_CHECKSUM_EN
  logic       dl_q,        dl_d;
  logic [7:0] sum_q,       sum_d;
  logic       sum_valid_q, sum_valid_d;

  always_comb begin
    dl_d        = dn_download;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    if (dn_download && !dl_q) begin
      sum_d       = '0;
      sum_valid_d = 1'b0;
    end
    if (w_accept) begin
      sum_d = sum_d + dn_data;
    end
    if (!dn_download && dl_q) begin
      sum_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dl_q        <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      dl_q        <= dl_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign dn_sum       = sum_q;
  assign dn_sum_valid = sum_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_port_arbiter
// Purpose  : Directed, table-driven self-checking bench for rom_port_arbiter.
//            Checksum checks are included when ROM_ARBITER_CHECKSUM_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_port_arbiter;

  localparam int ADDR_W = 14;
  localparam int ROM_SZ = 32'h3000;
  localparam int HOLD   = 20;

  logic              clk;
  logic              reset_n;
  logic              dn_download;
  logic              dn_wr;
  logic [ADDR_W-1:0] dn_addr;
  logic [7:0]        dn_data;
  logic              dn_wait;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_ack;
  logic [7:0]        vid_data;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic [7:0]        mem_q;
  logic              game_reset_n;
`ifdef ROM_ARBITER_CHECKSUM_EN
  logic [7:0]        dn_sum;
  logic              dn_sum_valid;
`endif

  rom_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .ROM_SIZE    (ROM_SZ),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .dn_download  (dn_download),
    .dn_wr        (dn_wr),
    .dn_addr      (dn_addr),
    .dn_data      (dn_data),
    .dn_wait      (dn_wait),
    .vid_req      (vid_req),
    .vid_addr     (vid_addr),
    .vid_ack      (vid_ack),
    .vid_data     (vid_data),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_ack      (cpu_ack),
    .cpu_data     (cpu_data),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .mem_q        (mem_q),
`ifdef ROM_ARBITER_CHECKSUM_EN
    .dn_sum       (dn_sum),
    .dn_sum_valid (dn_sum_valid),
`endif
    .game_reset_n (game_reset_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory, read data registered one cycle.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_q <= mem[mem_addr];
  end

  typedef struct {
    logic        dl;
    logic        wr;
    logic [13:0] waddr;
    logic [7:0]  wdata;
    logic        vreq;
    logic [13:0] vaddr;
    logic        creq;
    logic [13:0] caddr;
    logic        e_wait;
    logic        e_we;
    logic [13:0] e_maddr;
    logic [7:0]  e_mdin;
    logic        e_vack;
    logic        e_cack;
    logic [7:0]  e_data;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic dl, logic wr, logic [13:0] wa, logic [7:0] wd,
                              logic vr, logic [13:0] va, logic cr, logic [13:0] ca,
                              logic ew, logic ewe, logic [13:0] ema, logic [7:0] emd,
                              logic eva, logic eca, logic [7:0] ed);
    vec_t v;
    v.dl = dl; v.wr = wr; v.waddr = wa; v.wdata = wd;
    v.vreq = vr; v.vaddr = va; v.creq = cr; v.caddr = ca;
    v.e_wait = ew; v.e_we = ewe; v.e_maddr = ema; v.e_mdin = emd;
    v.e_vack = eva; v.e_cack = eca; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      dn_download = vq[i].dl;
      dn_wr       = vq[i].wr;
      dn_addr     = vq[i].waddr;
      dn_data     = vq[i].wdata;
      vid_req     = vq[i].vreq;
      vid_addr    = vq[i].vaddr;
      cpu_req     = vq[i].creq;
      cpu_addr    = vq[i].caddr;
      tick();
      chk($sformatf("v%0d_dn_wait", i), 32'(dn_wait), 32'(vq[i].e_wait));
      chk($sformatf("v%0d_mem_we", i),  32'(mem_we),  32'(vq[i].e_we));
      chk($sformatf("v%0d_vid_ack", i), 32'(vid_ack), 32'(vq[i].e_vack));
      chk($sformatf("v%0d_cpu_ack", i), 32'(cpu_ack), 32'(vq[i].e_cack));
      if (vq[i].e_we) begin
        chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vq[i].e_maddr));
        chk($sformatf("v%0d_mem_din", i),  32'(mem_din),  32'(vq[i].e_mdin));
      end
      if (vq[i].e_vack) chk($sformatf("v%0d_vid_data", i), 32'(vid_data), 32'(vq[i].e_data));
      if (vq[i].e_cack) chk($sformatf("v%0d_cpu_data", i), 32'(cpu_data), 32'(vq[i].e_data));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks, wes, rise;

    // download: 3 bytes, then an out-of-range strobe
    vq.push_back(mk(1,0,14'h0000,8'h00, 0,0,0,0, 0,0,14'h0000,8'h00, 0,0,8'h00)); // 0
    vq.push_back(mk(1,1,14'h0000,8'hA5, 0,0,0,0, 1,0,14'h0000,8'h00, 0,0,8'h00)); // 1
    vq.push_back(mk(1,0,14'h0000,8'h00, 0,0,0,0, 0,1,14'h0000,8'hA5, 0,0,8'h00)); // 2
    vq.push_back(mk(1,1,14'h0001,8'h5A, 0,0,0,0, 1,0,14'h0000,8'h00, 0,0,8'h00)); // 3
    vq.push_back(mk(1,0,14'h0000,8'h00, 0,0,0,0, 0,1,14'h0001,8'h5A, 0,0,8'h00)); // 4
    vq.push_back(mk(1,1,14'h0002,8'hFF, 0,0,0,0, 1,0,14'h0000,8'h00, 0,0,8'h00)); // 5
    vq.push_back(mk(1,0,14'h0000,8'h00, 0,0,0,0, 0,1,14'h0002,8'hFF, 0,0,8'h00)); // 6
    vq.push_back(mk(1,1,14'h3FFF,8'h77, 0,0,0,0, 0,0,14'h0000,8'h00, 0,0,8'h00)); // 7
    vq.push_back(mk(1,0,14'h0000,8'h00, 0,0,0,0, 0,0,14'h0000,8'h00, 0,0,8'h00)); // 8
    vq.push_back(mk(0,0,14'h0000,8'h00, 0,0,0,0, 0,0,14'h0000,8'h00, 0,0,8'h00)); // 9
    // back-to-back strobe while buffer full: second byte dropped
    vq.push_back(mk(0,1,14'h0003,8'h12, 0,0,0,0, 1,0,14'h0000,8'h00, 0,0,8'h00)); // 10
    vq.push_back(mk(0,1,14'h0004,8'h34, 0,0,0,0, 0,1,14'h0003,8'h12, 0,0,8'h00)); // 11
    vq.push_back(mk(0,0,14'h0000,8'h00, 0,0,0,0, 0,0,14'h0000,8'h00, 0,0,8'h00)); // 12
    // simultaneous video + CPU requests: video first, CPU two cycles later
    vq.push_back(mk(0,0,0,0, 1,14'h0010,1,14'h0020, 0,0,0,0, 0,0,8'h00)); // 13
    vq.push_back(mk(0,0,0,0, 1,14'h0010,1,14'h0020, 0,0,0,0, 0,0,8'h00)); // 14
    vq.push_back(mk(0,0,0,0, 1,14'h0010,1,14'h0020, 0,0,0,0, 1,0,8'h11)); // 15
    vq.push_back(mk(0,0,0,0, 1,14'h0010,1,14'h0020, 0,0,0,0, 0,0,8'h00)); // 16
    vq.push_back(mk(0,0,0,0, 0,14'h0010,1,14'h0020, 0,0,0,0, 0,1,8'h22)); // 17
    vq.push_back(mk(0,0,0,0, 0,14'h0010,1,14'h0020, 0,0,0,0, 0,0,8'h00)); // 18
    vq.push_back(mk(0,0,0,0, 0,14'h0010,0,14'h0020, 0,0,0,0, 0,0,8'h00)); // 19

    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 8'h00;
    mem[16] = 8'h11;
    mem[32] = 8'h22;

    reset_n = 1'b0; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    vid_req = 1'b0; vid_addr = '0; cpu_req = 1'b0; cpu_addr = '0;
    repeat (3) tick();
    chk("rst_dn_wait", 32'(dn_wait), 0);
    chk("rst_vid_ack", 32'(vid_ack), 0);
    chk("rst_cpu_ack", 32'(cpu_ack), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_din", 32'(mem_din), 0);
    chk("rst_vid_data", 32'(vid_data), 0);
    chk("rst_cpu_data", 32'(cpu_data), 0);
    chk("rst_game_reset_n", 32'(game_reset_n), 0);
`ifdef ROM_ARBITER_CHECKSUM_EN
    chk("rst_sum_valid", 32'(dn_sum_valid), 0);
`endif

    reset_n = 1'b1;
    n = 0;
    while (!game_reset_n && n < HOLD + 10) begin
      tick();
      n++;
    end
    chk("game_reset_hold", 32'(n), 32'(HOLD));

    run_vecs(0, 9);
`ifdef ROM_ARBITER_CHECKSUM_EN
    chk("sum_value", 32'(dn_sum), 32'h0FE);
    chk("sum_valid", 32'(dn_sum_valid), 1);
`endif
    run_vecs(10, 19);

    // CPU request stalled by an active download
    dn_download = 1'b1; cpu_req = 1'b1; cpu_addr = 14'h0020;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      acks += int'(cpu_ack);
    end
    chk("stall_no_ack", 32'(acks), 0);
    chk("stall_game_reset_n", 32'(game_reset_n), 0);
`ifdef ROM_ARBITER_CHECKSUM_EN
    chk("sum_valid_cleared", 32'(dn_sum_valid), 0);
`endif
    dn_download = 1'b0;
    tick();
    chk("stall_release_edge_ack", 32'(cpu_ack), 0);
    n = 0;
    while (!cpu_ack && n < 10) begin
      tick();
      n++;
    end
    chk("stall_release_latency", 32'(n), 2);
    chk("stall_release_data", 32'(cpu_data), 32'h22);
    tick();
    cpu_req = 1'b0;
    chk("stall_single_ack", 32'(cpu_ack), 0);

    n = 0;
    while (!game_reset_n && n < HOLD + 10) begin
      tick();
      n++;
    end
    chk("pre_abort_game_reset_n", 32'(game_reset_n), 1);

    // reset mid-read with a buffered write pending
    vid_req = 1'b1; vid_addr = 14'h0010;
    dn_wr = 1'b1; dn_addr = 14'h0005; dn_data = 8'h99;
    tick();
    chk("abort_buf_full", 32'(dn_wait), 1);
    dn_wr = 1'b0; vid_req = 1'b0; reset_n = 1'b0;
    tick();
    chk("abort_vid_ack", 32'(vid_ack), 0);
    chk("abort_dn_wait", 32'(dn_wait), 0);
    chk("abort_mem_we", 32'(mem_we), 0);
    chk("abort_game_reset_n", 32'(game_reset_n), 0);
    reset_n = 1'b1;
    acks = 0; wes = 0; rise = 0;
    for (int i = 0; i < HOLD + 5; i++) begin
      tick();
      acks += int'(vid_ack);
      wes  += int'(mem_we);
      if (game_reset_n && rise == 0) rise = i + 1;
    end
    chk("abort_no_ack", 32'(acks), 0);
    chk("abort_write_lost", 32'(wes), 0);
    chk("abort_counter_reload", 32'(rise), 32'(HOLD));

    // arbiter is idle again: fresh read completes with normal latency
    cpu_req = 1'b1; cpu_addr = 14'h0010;
    tick();
    n = 0;
    while (!cpu_ack && n < 10) begin
      tick();
      n++;
    end
    chk("post_abort_latency", 32'(n), 2);
    chk("post_abort_data", 32'(cpu_data), 32'h11);
    tick();
    cpu_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
